rgb_1: RTL and testbench

RGB_1 -- requirements
Module: rgb_1

---
 rtl/rgb_1.sv | 76 +++++++
 tb/tb_rgb_1.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rgb_1.sv
// rgb_1 - colour gate for a text-mode VGA pixel pipeline.
//
// Three push buttons select which colour channels light up for foreground
// (text) pixels. Each button is synchronized with two flops and then
// debounced. The debounced enable flips only after the synchronized level
// has differed from it for DEBOUNCE_CYCLES consecutive edges. Inside the
// active video area, a foreground pixel drives every enabled channel to full
// intensity. Everything else is black.
//
// Ports
//   clk                  : single clock, rising edge
//   reset                : synchronous, active-high reset
//   BotonR/BotonG/BotonB : asynchronous button levels, 1 = pressed
//   BIT_FUENTE           : font pixel bit, 1 = foreground
//   H_ON, V_ON           : horizontal / vertical active-video flags
//   R, G, B              : registered 4-bit channel intensities

module rgb_1 #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BotonR,
  input  logic       BotonG,
  input  logic       BotonB,
  input  logic       BIT_FUENTE,
  input  logic       H_ON,
  input  logic       V_ON,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit index per channel: 0 = red, 1 = green, 2 = blue.
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    en;
  logic [CW-1:0] cnt [3];

  logic pix_on;
  assign pix_on = H_ON & V_ON & BIT_FUENTE;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      en    <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      R     <= 4'h0;
      G     <= 4'h0;
      B     <= 4'h0;
    end else begin
      sync1 <= {BotonB, BotonG, BotonR};
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == en[i]) begin
          // Level agrees with the debounced state: any partial count was a glitch.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          en[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      R <= (pix_on && en[0]) ? 4'hF : 4'h0;
      G <= (pix_on && en[1]) ? 4'hF : 4'h0;
      B <= (pix_on && en[2]) ? 4'hF : 4'h0;
    end
  end

endmodule

// File: tb/tb_rgb_1.sv
module tb_rgb_1;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       BotonR, BotonG, BotonB;
  logic       BIT_FUENTE, H_ON, V_ON;
  logic [3:0] R, G, B;

  int tests = 0;
  int fails = 0;

  rgb_1 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .BotonR     (BotonR),
    .BotonG     (BotonG),
    .BotonB     (BotonB),
    .BIT_FUENTE (BIT_FUENTE),
    .H_ON       (H_ON),
    .V_ON       (V_ON),
    .R          (R),
    .G          (G),
    .B          (B)
  );

  always #5 clk = ~clk;

  // One rising edge; inputs are then changed and outputs sampled 1 ns later.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {BotonR, BotonG, BotonB, BIT_FUENTE, H_ON, V_ON} = '0;
    tick(2);
    chk("reset_rgb", {R, G, B}, 12'h000);
    chk("reset_en", {13'd0, dut.en}, 16'h0);
    reset = 1'b0;

    // Idle with all inputs low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_rgb", {R, G, B}, 12'h000);
    end

    // Press R, G, B in turn outside the active area.
    BIT_FUENTE = 1'b1;
    BotonR = 1'b1;
    tick(D + 1);
    chk("en_r_early", {15'd0, dut.en[0]}, 16'h0);
    tick();
    chk("en_r_set", {15'd0, dut.en[0]}, 16'h1);
    chk("blank_r", {R, G, B}, 12'h000);
    BotonG = 1'b1;
    tick(D + 1);
    chk("en_g_early", {15'd0, dut.en[1]}, 16'h0);
    tick();
    chk("en_g_set", {15'd0, dut.en[1]}, 16'h1);
    BotonB = 1'b1;
    tick(D + 1);
    chk("en_b_early", {15'd0, dut.en[2]}, 16'h0);
    tick();
    chk("en_b_set", {15'd0, dut.en[2]}, 16'h1);
    chk("blank_all", {R, G, B}, 12'h000);

    // H_ON alone is not active video.
    H_ON = 1'b1;
    tick();
    chk("h_only", {R, G, B}, 12'h000);

    // Active video: white text, one edge of latency.
    V_ON = 1'b1;
    tick();
    chk("white", {R, G, B}, 12'hFFF);

    // Background is black.
    BIT_FUENTE = 1'b0;
    tick();
    chk("background", {R, G, B}, 12'h000);

    // Release G and B. Their enables drop D+2 edges later; output follows one edge after.
    BIT_FUENTE = 1'b1;
    BotonG = 1'b0;
    BotonB = 1'b0;
    tick(D + 2);
    chk("release_edge", {R, G, B}, 12'hFFF);
    tick();
    chk("red_only", {R, G, B}, 12'hF00);

    // A G glitch of D-1 edges must not enable green.
    BotonG = 1'b1;
    tick(D - 1);
    BotonG = 1'b0;
    for (int i = 0; i < D + 4; i++) begin
      tick();
      chk("glitch_g", {R, G, B}, 12'hF00);
    end
    chk("glitch_en_g", {15'd0, dut.en[1]}, 16'h0);

    // Reset in the middle of a B debounce (counter at 2).
    BotonB = 1'b1;
    tick(4);
    chk("mid_cnt_b", 16'(dut.cnt[2]), 16'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_abort", {R, G, B}, 12'h000);
    chk("rst_cnt_b", 16'(dut.cnt[2]), 16'd0);
    tick(D + 2);
    chk("post_rst_early", {R, G, B}, 12'h000);
    tick();
    chk("post_rst_rb", {R, G, B}, 12'hF0F);

    // Leaving active video blanks everything, one edge later.
    V_ON = 1'b0;
    tick();
    chk("v_off", {R, G, B}, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
